// File: rtl/tiny16_pkg.sv
// Shared tiny16 memory definitions: state encoding and default bus widths.
// No logic, so no latency or backpressure of its own.
package tiny16_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 16;

   typedef enum logic {
      MEM_CLEAR = 1'b0,
      MEM_IDLE  = 1'b1
   } mem_state_t;

endpackage

// File: rtl/memory_array.sv
// Single-port synchronous RAM with a registered read. Read latency 1, write latency 0.
// No backpressure: one access is taken every cycle.
module memory_array #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Contents are never reset; the bank's zero-fill sweep clears them.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/memory_bank.sv
// Address-register front end for a single-port RAM, with an optional zero-fill sweep after reset.
// Read latency 1, write latency 0. Not ready during the sweep: accesses are dropped and flagged on err.
module memory_bank
   import tiny16_pkg::*;
#(
   parameter int DATA_W         = DATA_W_DEF,
   parameter int ADDR_W         = ADDR_W_DEF,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              addr_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic              addr_inc,
   input  logic              in_en,
   input  logic [DATA_W-1:0] in,
   input  logic              out_en,
   output logic [DATA_W-1:0] out,
   output logic              out_valid,
   output logic              ready,
   output logic              err
);

   localparam mem_state_t RESET_STATE = CLEAR_ON_RESET ? MEM_CLEAR : MEM_IDLE;

   mem_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic              out_valid_q, rd_acc;
   logic              err_q, err_d;
   logic [DATA_W-1:0] out_hold_q;

   logic              arr_we;
   logic [ADDR_W-1:0] arr_addr;
   logic [DATA_W-1:0] arr_wdata;
   logic [DATA_W-1:0] arr_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RESET_STATE;
         addr_q      <= '0;
         clr_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
         out_hold_q  <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         clr_cnt_q   <= clr_cnt_d;
         out_valid_q <= rd_acc;
         err_q       <= err_d;
         // Capture the read word once, so out holds while the array port moves on.
         if (out_valid_q) begin
            out_hold_q <= arr_rdata;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      clr_cnt_d = clr_cnt_q;
      rd_acc    = 1'b0;
      err_d     = 1'b0;
      arr_we    = 1'b0;
      arr_addr  = addr_q;
      arr_wdata = in;
      case (state_q)
         MEM_CLEAR: begin
            arr_we    = 1'b1;
            arr_addr  = clr_cnt_q;
            arr_wdata = '0;
            err_d     = in_en | out_en;
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            if (clr_cnt_q == '1) begin
               state_d = MEM_IDLE;
            end
         end
         MEM_IDLE: begin
            // A simultaneous read and write keeps the write and drops the read.
            arr_we = in_en;
            rd_acc = out_en & ~in_en;
            err_d  = in_en & out_en;
            if (addr_en) begin
               addr_d = addr;
            end else if ((in_en | out_en) && addr_inc) begin
               addr_d = addr_q + ADDR_W'(1);
            end
         end
         default: state_d = RESET_STATE;
      endcase
   end

   memory_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .addr  (arr_addr),
      .wdata (arr_wdata),
      .rdata (arr_rdata)
   );

   assign out       = out_valid_q ? arr_rdata : out_hold_q;
   assign out_valid = out_valid_q;
   assign ready     = (state_q == MEM_IDLE);
   assign err       = err_q;

endmodule

// File: doc/memory_bank.md
# memory_bank

Parametrised successor to the tiny16 main memory: a single-port synchronous RAM behind an internal address register, with post-increment addressing, registered reads that carry a valid strobe, access-conflict detection and an optional zero-fill sweep after reset. It sits between the CPU datapath and the RAM array. It keeps the `addr_en` / `in_en` / `out_en` strobe protocol so the existing control unit drives it unchanged.

## Interface
- `DATA_W`, 16, data word width
- `ADDR_W`, 16, address width; depth = 2^ADDR_W words
- `CLEAR_ON_RESET`, 1, when 1 the block zero-fills the array after reset; when 0 it does not
- `clk`  in  1  clock, all state updates on the rising edge
- `rst_n`  in  1  reset: one clock; reset is asynchronous and active-low
- `addr_en`  in  1  load the address register from `addr`
- `addr`  in  ADDR_W  address to load
- `addr_inc`  in  1  post-increment the address register after an accepted access
- `in_en`  in  1  write `in` to mem[address register]
- `in`  in  DATA_W  write data
- `out_en`  in  1  read mem[address register]
- `out`  out  DATA_W  registered read data; holds until the next accepted read
- `out_valid`  out  1  one-cycle pulse, high in the cycle after an accepted read
- `ready`  out  1  high when accesses are accepted (state IDLE)
- `err`  out  1  one-cycle pulse on a rejected or conflicting access

## Operation
- States are CLEAR and IDLE. `ready` = (state == IDLE).
- Reset state is CLEAR when CLEAR_ON_RESET=1, otherwise IDLE.
- CLEAR:
  - The clear counter steps 0 → 2^ADDR_W−1 and writes 0 to one word per cycle.
  - After the final write, the state goes to IDLE.
  - All strobes are ignored. Any `in_en` or `out_en` pulses `err`. `addr_en` is ignored.
- IDLE, accesses are evaluated per edge:
  - `in_en` only: write mem[addr_reg] ← `in`.
  - `out_en` only: `out` ← mem[addr_reg]; `out_valid` pulses.
  - `in_en` and `out_en` together: the write is performed, the read is dropped. `out` is unchanged, `out_valid` stays 0, `err` pulses.
- Address register update, in priority order:
  1. `addr_en`: addr_reg ← `addr`. An access in the same cycle uses the old addr_reg.
  2. Else, accepted access with `addr_inc`=1: addr_reg ← addr_reg+1, modulo 2^ADDR_W (2^ADDR_W−1 wraps to 0).
  3. Else addr_reg holds.
- Read-after-write: a read in the cycle after a write to the same address returns the new data.
- Memory contents are never reset. Only the zero-fill sweep clears them.

## Timing
- Reset values while `rst_n`=0:
  - addr_reg=0, `out`=0, `out_valid`=0, `err`=0, clear counter=0.
  - `ready`=0 when CLEAR_ON_RESET=1; `ready`=1 when CLEAR_ON_RESET=0.
- Clear duration: `ready` rises 2^ADDR_W cycles after the first rising edge with `rst_n`=1.
- Read latency is 1: `out_en` is sampled at edge N; `out` and `out_valid` are valid after edge N.
- Write latency is 0: the array updates at the sampling edge.
- `err` is asserted after the offending edge, for one cycle.
- Asserting `rst_n`=0 mid-clear aborts the sweep. After release, the clear restarts from word 0 with the full 2^ADDR_W duration.
- Asserting `rst_n`=0 mid-read drops the pending `out_valid`.

## Structure
- Shared package `tiny16_pkg` holds:
  - state encoding constants `MEM_CLEAR` and `MEM_IDLE`
  - default `DATA_W` and `ADDR_W`
- One sub-module: `memory_array`, a plain synchronous single-port RAM (`we`, `addr`, `wdata`, registered `rdata`).
- `memory_bank` owns the FSM, the address register, the clear counter and the write/read arbitration into the array port. During CLEAR the clear counter drives the array port.

## Test plan
- Run with ADDR_W=4, CLEAR_ON_RESET=1. Release reset → `ready` low for exactly 16 cycles, then high. Load addr 5 and read → `out`=0x0000 with `out_valid`=1 one cycle later.
- Load addr 0, write 0x1234. Load addr 1, write 0x4321. Read addr 0, then addr 1 → `out`=0x1234, then 0x4321, each with a one-cycle `out_valid` pulse.
- Load addr 0xE. Write 0xAAAA, 0xBBBB, 0xCCCC with `addr_inc`=1 → data lands at 0xE, 0xF, 0x0 (wrap) and addr_reg ends at 0x1. An incrementing read burst from 0xE returns the same three values.
- At addr 3, assert `in_en`=1, `in`=0x5555 and `out_en`=1 in the same cycle → `err` pulses, `out_valid`=0, `out` unchanged. A following read of addr 3 returns 0x5555.
- Assert `addr_en` with `addr`=7 and `in_en` with `in`=0x9999 in the same cycle while addr_reg=2 → 0x9999 is written to addr 2 and addr_reg becomes 7.
- Pull `rst_n` low at cycle 8 of the clear → `ready` stays low, then 16 further cycles pass after release before `ready` rises. `in_en` during CLEAR pulses `err` and the write is not performed (a read after `ready` rises returns 0).
